// File: rtl/clock_pkg.sv
// Shared constants and helpers for the clock register-file datapath.
// Field indices, ALU op encodings, field limits/bases and one-hot decode helpers.
package clock_pkg;

  localparam int W  = 6;
  localparam int NF = 10;

  localparam int SEC  = 0;
  localparam int MIN  = 1;
  localparam int HR   = 2;
  localparam int DAY  = 3;
  localparam int MON  = 4;
  localparam int YR   = 5;
  localparam int AMIN = 6;
  localparam int AHR  = 7;
  localparam int SCR0 = 8;
  localparam int SCR1 = 9;

  typedef enum logic [1:0] {
    OP_INC   = 2'b00,
    OP_PASSB = 2'b01,
    OP_SUB   = 2'b10,
    OP_ZERO  = 2'b11
  } alu_op_e;

  // Limits are 7 bits wide so that the full-range value 64 is representable.
  localparam logic [W:0]   LIM_SEC   = 7'd60;
  localparam logic [W:0]   LIM_MIN   = 7'd60;
  localparam logic [W:0]   LIM_HR    = 7'd24;
  localparam logic [W:0]   LIM_MON   = 7'd13;
  localparam logic [W:0]   LIM_FULL  = 7'd64;
  localparam logic [W-1:0] BASE_DAY  = 6'd1;
  localparam logic [W-1:0] BASE_MON  = 6'd1;
  localparam logic [W-1:0] BASE_ZERO = 6'd0;

  function automatic logic is_onehot(input logic [NF-1:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] onehot_idx(input logic [NF-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NF; i++) begin
      if (v[i]) idx = 4'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/clock_field_limit.sv
// Wrap limit and wrap base for the field selected by a one-hot select,
// including calendar-aware month length with the leap-year rule yr[1:0]==0.
module clock_field_limit
  import clock_pkg::*;
(
  input  logic [NF-1:0] sel_i,
  input  logic [W-1:0]  mon_i,
  input  logic [W-1:0]  yr_i,
  output logic [W:0]    limit_o,
  output logic [W-1:0]  base_o
);

  logic       leap_s;
  logic [4:0] dim_s;

  // Days in the selected month; invalid months fall back to 31.
  always_comb begin
    leap_s = ((yr_i & 6'd3) == 6'd0);
    case (mon_i)
      6'd2: begin
        if (leap_s) dim_s = 5'd29;
        else        dim_s = 5'd28;
      end
      6'd4, 6'd6, 6'd9, 6'd11: dim_s = 5'd30;
      default:                 dim_s = 5'd31;
    endcase
  end

  // Per-field limit/base; anything not matching a wrapping field wraps at 64 to 0.
  always_comb begin
    limit_o = LIM_FULL;
    base_o  = BASE_ZERO;
    case (sel_i)
      (10'b1 << SEC): limit_o = LIM_SEC;
      (10'b1 << MIN): limit_o = LIM_MIN;
      (10'b1 << HR):  limit_o = LIM_HR;
      (10'b1 << DAY): begin
        limit_o = {2'b00, dim_s} + 7'd1;
        base_o  = BASE_DAY;
      end
      (10'b1 << MON): begin
        limit_o = LIM_MON;
        base_o  = BASE_MON;
      end
      default: begin
        limit_o = LIM_FULL;
        base_o  = BASE_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/clock_datapath.sv
// Clock datapath: register file, A/B/R with field-aware ALU, keypad digit
// buffer, one-second prescaler and the status flags returned to the sequencers.
module clock_datapath
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 500
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NF-1:0] T,
  input  logic [1:0]    s,
  input  logic          La,
  input  logic          Lb,
  input  logic          Lr,
  input  logic          Er,
  input  logic          Kc,
  input  logic          Cc,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic [3:0]    rd_sel,
  output logic [W-1:0]  rd_data,
  output logic          t,
  output logic          u,
  output logic          k7,
  output logic          c7,
  output logic          Az,
  output logic          M
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0]  field_q [NF];
  logic [W-1:0]  a_q, b_q, r_q;
  logic          c7_q, t_q, u_q, m_q;
  logic [PW-1:0] pre_q;
  logic [1:0]    kcnt_q, kcnt_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic          u_d;

  logic          oh_s;
  logic [3:0]    fidx_s;
  logic [W:0]    lim_s;
  logic [W-1:0]  base_s;
  logic [W:0]    inc_s;
  logic [W-1:0]  alu_r_s;
  logic          alu_c_s;
  logic [W-1:0]  keyval_s;
  logic          tc_s;

  assign oh_s   = is_onehot(T);
  assign fidx_s = onehot_idx(T);
  assign inc_s  = {1'b0, a_q} + 7'd1;
  assign tc_s   = (pre_q == PW'(TICK_DIV - 1));

  clock_field_limit u_limit (
    .sel_i   (T),
    .mon_i   (field_q[MON]),
    .yr_i    (field_q[YR]),
    .limit_o (lim_s),
    .base_o  (base_s)
  );

  // ALU result and carry/borrow for the current op.
  always_comb begin
    alu_r_s = 6'd0;
    alu_c_s = 1'b0;
    case (alu_op_e'(s))
      OP_INC: begin
        if (inc_s >= lim_s) begin
          alu_r_s = base_s;
          alu_c_s = 1'b1;
        end else begin
          alu_r_s = inc_s[W-1:0];
          alu_c_s = 1'b0;
        end
      end
      OP_PASSB: alu_r_s = b_q;
      OP_SUB: begin
        alu_r_s = a_q - b_q;
        alu_c_s = (a_q < b_q);
      end
      OP_ZERO: alu_r_s = 6'd0;
      default: begin
        alu_r_s = 6'd0;
        alu_c_s = 1'b0;
      end
    endcase
  end

  // Numeric value of the held keypad digits.
  always_comb begin
    case (kcnt_q)
      2'd2:    keyval_s = 6'(tens_q) * 6'd10 + 6'(units_q);
      2'd1:    keyval_s = {2'b00, units_q};
      default: keyval_s = 6'd0;
    endcase
  end

  // Key buffer next state; Kc wins over a same-cycle digit.
  always_comb begin
    kcnt_d  = kcnt_q;
    tens_d  = tens_q;
    units_d = units_q;
    if (Kc) begin
      kcnt_d  = 2'd0;
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (key_valid && (key_code <= 4'd9) && (kcnt_q < 2'd2)) begin
      kcnt_d  = kcnt_q + 2'd1;
      tens_d  = units_q;
      units_d = key_code;
    end else begin
      kcnt_d  = kcnt_q;
      tens_d  = tens_q;
      units_d = units_q;
    end
  end

  // Update-pending flag: a tick wins over a same-cycle clear.
  always_comb begin
    if (t_q)               u_d = 1'b1;
    else if (Er && T[SEC]) u_d = 1'b0;
    else                   u_d = u_q;
  end

  // Register file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) begin
        if (i == DAY || i == MON) field_q[i] <= 6'd1;
        else                      field_q[i] <= 6'd0;
      end
    end else if (Er && oh_s) begin
      field_q[fidx_s] <= r_q;
    end
  end

  // Operand/result registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 6'd0;
      b_q  <= 6'd0;
      r_q  <= 6'd0;
      c7_q <= 1'b0;
      m_q  <= 1'b0;
    end else begin
      if (La) a_q <= oh_s ? field_q[fidx_s] : 6'd0;
      if (Lb) b_q <= keyval_s;
      if (Lr) begin
        r_q  <= alu_r_s;
        c7_q <= alu_c_s;
      end
      if (Cc) m_q <= (field_q[HR] == field_q[AHR]) && (field_q[MIN] == field_q[AMIN]);
    end
  end

  // Key buffer, prescaler and tick/update flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt_q  <= 2'd0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      pre_q   <= '0;
      t_q     <= 1'b0;
      u_q     <= 1'b0;
    end else begin
      kcnt_q  <= kcnt_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      pre_q   <= tc_s ? '0 : pre_q + PW'(1);
      t_q     <= tc_s;
      u_q     <= u_d;
    end
  end

  assign rd_data = (rd_sel <= 4'd9) ? field_q[rd_sel] : 6'd0;
  assign t       = t_q;
  assign u       = u_q;
  assign k7      = (kcnt_q == 2'd2);
  assign c7      = c7_q;
  assign Az      = (r_q == 6'd0);
  assign M       = m_q;

endmodule

// File: doc/clock_datapath.md
# clock_datapath

Register-file datapath that executes the micro-orders issued by the PLA sequencers (timer set, time update, timer compare) and returns their status inputs. It sits on the other side of the control/status interface: it holds the calendar/time/alarm fields, runs the 6-bit ALU with field-aware wrap, buffers keypad digits, and generates the one-second tick.

## Interface
Parameters:
- TICK_DIV, 500, `clk` cycles per one-second tick (500 × 2 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- T  in  10  one-hot field select: 0 sec, 1 min, 2 hr, 3 day, 4 mon, 5 yr, 6 alarm min, 7 alarm hr, 8 and 9 scratch.
- s  in  2  ALU op: 00 A+1 with wrap, 01 pass B, 10 A−B, 11 zero.
- La, Lb, Lr, Er, Kc, Cc  in  1 each  load A, load B, load R, write R to field, clear keys, alarm compare.
- key_valid  in  1  one-cycle keypad strobe.
- key_code  in  4  keypad code; 0–9 are digits.
- rd_sel  in  4  display read index.
- rd_data  out  6  field[rd_sel], combinational; 0 if rd_sel > 9.
- t  out  1  one-cycle tick strobe.
- u  out  1  update pending (latched tick).
- k7  out  1  key entry complete (two digits held).
- c7  out  1  wrap/borrow of last Lr.
- Az  out  1  R == 0.
- M  out  1  alarm match.

## Operation
- All fields, A, B and R are 6 bits. The year field is stored as year − 2000 (0–63); a year is leap when yr[1:0] == 0.
- La: A <= field[T]. If T is not one-hot, A <= 0.
- Lb: B <= key value.
  - Two digits held: key value = tens × 10 + units.
  - One digit held: key value = units.
  - No digits held: key value = 0.
- Lr: R <= ALU(A, B).
  - s=00: if A+1 ≥ limit(T), R <= base(T) and c7 <= 1; otherwise R <= A+1 and c7 <= 0.
  - s=10: R <= (A−B) mod 64; c7 <= (A < B).
  - s=01 and s=11: c7 <= 0.
- Limits and bases:
  - limit: sec/min 60, hr 24, day days_in_month(mon, yr) + 1, mon 13; all other fields 64.
  - base: day and mon 1; all other fields 0.
  - days_in_month: 31, 30, or 28/29 for February.
  - Invalid mon (0 or > 12) is treated as 31 days.
- Er: field[T] <= R. If T is not one-hot, no write.
- Every register updates from pre-edge values. La+Lr in the same cycle: R uses the old A. Lr+Er in the same cycle: the field gets the old R.
- Key buffer:
  - A digit key is accepted when fewer than 2 digits are held. The existing digit moves to tens.
  - Non-digit codes are ignored. Digits arriving while full are dropped.
  - k7 = (count == 2).
  - Kc clears the count and both digits. Kc wins over a same-cycle key_valid, and that key is lost.
- Tick:
  - The prescaler counts 0..TICK_DIV−1; t pulses on the terminal count.
  - u is set by t and cleared by Er with T[0].
  - If t and the clear occur in the same cycle, u stays 1.
- Cc: M <= (hr == alarm hr) && (min == alarm min). M holds until the next Cc.
- Az = (R == 0), combinational from R.

## Timing
- Reset values:
  - Fields: sec 0, min 0, hr 0, day 1, mon 1, yr 0, alarms 0, scratch 0.
  - A, B, R, prescaler, key buffer: 0.
  - Outputs: t, u, k7, c7, M = 0. Az = 1.
- Latency:
  - La/Lb/Lr/Er/Kc/Cc take effect at the next rising edge; statuses are valid in the following cycle.
  - A full increment takes La → Lr → Er = 3 cycles.
- First t occurs TICK_DIV cycles after reset release. Reset mid-count restarts the prescaler.
- key_valid is sampled every edge. There is no ack; the sequencer polls k7.

## Structure
- Package clock_pkg holds:
  - field index constants (SEC..SCR1);
  - ALU op encodings (OP_INC, OP_PASSB, OP_SUB, OP_ZERO);
  - field limits and bases;
  - the 6-bit width constant.
- Sub-module clock_field_limit: combinational; inputs T, mon, yr; outputs limit and base, including days_in_month and leap.
- Top level holds the register file, A/B/R, the ALU, the key buffer, the prescaler and the status logic.

## Test plan
- Reset, then release; hold 500 cycles → t pulses exactly at cycle 500; u = 1; rd_sel=3 reads 1 and rd_sel=4 reads 1.
- sec = 59; T=1<<0, s=00; La, Lr, Er on consecutive cycles → R = 0, c7 = 1, sec = 0, u cleared.
- mon = 2, yr = 24, day = 29; increment day → day = 1, c7 = 1. Repeat with yr = 23, day = 28 → day = 1.
- Keys 4, 2, 7 → k7 = 1 after 2; 7 dropped; Lb → B = 42. Kc together with key 5 → count 0, k7 = 0.
- alarm hr = 7, alarm min = 30; hr = 7, min = 30; Cc → M = 1. Then min = 31; Cc → M = 0.
- A = 5, B = 9, s=10, Lr → R = 60, c7 = 1, Az = 0. Then A = 9 → R = 0, Az = 1. T = 0b11 with Er → no field changes.
